// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the RV32I core: captures decode fields, forwards
// operands from EX/MEM/WB, inserts load-use bubbles and squashes on flush.
module id_ex_operand_stage #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [AWIDTH-1:0] id_pc_i,
    input  logic [31:0]       id_insn_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_regwren_i,
    input  logic              id_memren_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    input  logic [DWIDTH-1:0] ex_result_i,
    input  logic              mem_regwren_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              wb_regwren_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [DWIDTH-1:0] wb_data_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [AWIDTH-1:0] ex_pc_o,
    output logic [31:0]       ex_insn_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_regwren_o,
    output logic              ex_memren_o,
    output logic [DWIDTH-1:0] ex_rs1data_o,
    output logic [DWIDTH-1:0] ex_rs2data_o,
    output logic [CWIDTH-1:0] stall_cnt_o,
    output logic [CWIDTH-1:0] flush_cnt_o
);

    logic              lu;
    logic              ex_fwd_en;
    logic [DWIDTH-1:0] rs1_fwd;
    logic [DWIDTH-1:0] rs2_fwd;

    // Bypass mux: x0 first, then youngest producer wins.
    function automatic logic [DWIDTH-1:0] fwd_sel(
        input logic [4:0]        addr,
        input logic [DWIDTH-1:0] rf_data,
        input logic              ex_en,
        input logic [4:0]        ex_rd,
        input logic [DWIDTH-1:0] ex_data,
        input logic              mem_en,
        input logic [4:0]        mem_rd,
        input logic [DWIDTH-1:0] mem_data,
        input logic              wb_en,
        input logic [4:0]        wb_rd,
        input logic [DWIDTH-1:0] wb_data
    );
        logic [DWIDTH-1:0] r;
        r = rf_data;
        if (addr == 5'd0)                    r = '0;
        else if (ex_en && ex_rd == addr)     r = ex_data;
        else if (mem_en && mem_rd == addr)   r = mem_data;
        else if (wb_en && wb_rd == addr)     r = wb_data;
        return r;
    endfunction

    always_comb begin
        lu = 1'b0;
        if (id_valid_i && ex_valid_o && ex_memren_o && ex_regwren_o && ex_rd_o != 5'd0)
            lu = (id_uses_rs1_i && id_rs1_i == ex_rd_o) ||
                 (id_uses_rs2_i && id_rs2_i == ex_rd_o);
    end

    assign stall_o   = lu && !flush_i;
    // A load's EX result is an address, never the loaded value.
    assign ex_fwd_en = ex_valid_o && ex_regwren_o && !ex_memren_o;

    always_comb begin
        rs1_fwd = fwd_sel(id_rs1_i, rs1data_i, ex_fwd_en, ex_rd_o, ex_result_i,
                          mem_regwren_i, mem_rd_i, mem_data_i,
                          wb_regwren_i, wb_rd_i, wb_data_i);
        rs2_fwd = fwd_sel(id_rs2_i, rs2data_i, ex_fwd_en, ex_rd_o, ex_result_i,
                          mem_regwren_i, mem_rd_i, mem_data_i,
                          wb_regwren_i, wb_rd_i, wb_data_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_insn_o    <= '0;
            ex_rd_o      <= '0;
            ex_regwren_o <= 1'b0;
            ex_memren_o  <= 1'b0;
            ex_rs1data_o <= '0;
            ex_rs2data_o <= '0;
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
        end else if (flush_i) begin
            ex_valid_o   <= 1'b0;
            ex_regwren_o <= 1'b0;
            ex_memren_o  <= 1'b0;
            if (flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CWIDTH'(1);
        end else if (stall_o) begin
            ex_valid_o   <= 1'b0;
            ex_regwren_o <= 1'b0;
            ex_memren_o  <= 1'b0;
            if (stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CWIDTH'(1);
        end else begin
            ex_valid_o   <= id_valid_i;
            ex_pc_o      <= id_pc_i;
            ex_insn_o    <= id_insn_i;
            ex_rd_o      <= id_rd_i;
            ex_regwren_o <= id_regwren_i && id_valid_i;
            ex_memren_o  <= id_memren_i && id_valid_i;
            ex_rs1data_o <= rs1_fwd;
            ex_rs2data_o <= rs2_fwd;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed decode sequences with
// hand-computed expected EX-stage contents, counters sized to 4 bits.
module tb_id_ex_operand_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid_i;
    logic [AW-1:0] id_pc_i;
    logic [31:0]   id_insn_i;
    logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
    logic          id_uses_rs1_i, id_uses_rs2_i, id_regwren_i, id_memren_i;
    logic [DW-1:0] rs1data_i, rs2data_i, ex_result_i;
    logic          mem_regwren_i, wb_regwren_i, flush_i;
    logic [4:0]    mem_rd_i, wb_rd_i;
    logic [DW-1:0] mem_data_i, wb_data_i;
    logic          stall_o, ex_valid_o, ex_regwren_o, ex_memren_o;
    logic [AW-1:0] ex_pc_o;
    logic [31:0]   ex_insn_o;
    logic [4:0]    ex_rd_o;
    logic [DW-1:0] ex_rs1data_o, ex_rs2data_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    id_ex_operand_stage #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_insn_i(id_insn_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_rd_i(id_rd_i), .id_regwren_i(id_regwren_i), .id_memren_i(id_memren_i),
        .rs1data_i(rs1data_i), .rs2data_i(rs2data_i), .ex_result_i(ex_result_i),
        .mem_regwren_i(mem_regwren_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .wb_regwren_i(wb_regwren_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_insn_o(ex_insn_o),
        .ex_rd_o(ex_rd_o), .ex_regwren_o(ex_regwren_o), .ex_memren_o(ex_memren_o),
        .ex_rs1data_o(ex_rs1data_o), .ex_rs2data_o(ex_rs2data_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          v;
        bit          c1;
        logic [31:0] d1;
        bit          c2;
        logic [31:0] d2;
        int          sc;
        int          fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input string name, input bit v, input bit c1, input logic [31:0] d1,
                                input bit c2, input logic [31:0] d2, input int sc, input int fc);
        exp_t e;
        e.name = name; e.v = v; e.c1 = c1; e.d1 = d1; e.c2 = c2; e.d2 = d2; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".valid"}, 32'(ex_valid_o), 32'(e.v));
                if (e.c1) chk({e.name, ".rs1"}, ex_rs1data_o, e.d1);
                if (e.c2) chk({e.name, ".rs2"}, ex_rs2data_o, e.d2);
                chk({e.name, ".stall_cnt"}, 32'(stall_cnt_o), 32'(e.sc));
                chk({e.name, ".flush_cnt"}, 32'(flush_cnt_o), 32'(e.fc));
            end
        end
    end

    task automatic idle();
        id_valid_i = 0; id_pc_i = id_pc_i + 4; id_insn_i = 32'h13;
        id_rs1_i = 0; id_rs2_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
        id_rd_i = 0; id_regwren_i = 0; id_memren_i = 0;
        rs1data_i = 0; rs2data_i = 0; ex_result_i = 0;
        mem_regwren_i = 0; mem_rd_i = 0; mem_data_i = 0;
        wb_regwren_i = 0; wb_rd_i = 0; wb_data_i = 0;
        flush_i = 0;
    endtask

    task automatic dec(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit wr, input bit ld,
                       input logic [31:0] d1, input logic [31:0] d2);
        id_valid_i = 1; id_rs1_i = rs1; id_uses_rs1_i = u1; id_rs2_i = rs2; id_uses_rs2_i = u2;
        id_rd_i = rd; id_regwren_i = wr; id_memren_i = ld; rs1data_i = d1; rs2data_i = d2;
    endtask

    // Check combinational stall for the driven cycle, queue the post-edge expectation.
    task automatic step(input exp_t e, input bit exp_stall);
        #1;
        chk({e.name, ".stall_o"}, 32'(stall_o), 32'(exp_stall));
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        id_pc_i = 32'h100;
        idle();
        rst = 1;
        #2;
        chk("reset.valid", 32'(ex_valid_o), 0);
        chk("reset.rs1", ex_rs1data_o, 0);
        chk("reset.counts", 32'({stall_cnt_o, flush_cnt_o}), 0);
        chk("reset.stall_o", 32'(stall_o), 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // RAW chain through EX forward
        idle(); dec(0, 1, 0, 0, 5, 1, 0, 32'h99, 32'h0);
        step(mk("addi", 1, 1, 0, 0, 0, 0, 0), 0);
        idle(); dec(5, 1, 5, 1, 6, 1, 0, 32'h123, 32'h123); ex_result_i = 7;
        step(mk("raw", 1, 1, 7, 1, 7, 0, 0), 0);
        idle();
        step(mk("gap", 0, 0, 0, 0, 0, 0, 0), 0);

        // Load-use: one bubble, then MEM supplies the load data
        idle(); dec(1, 1, 0, 0, 7, 1, 1, 32'h1000, 0);
        step(mk("lw", 1, 1, 32'h1000, 0, 0, 0, 0), 0);
        idle(); dec(7, 1, 2, 1, 8, 1, 0, 32'h0, 32'h22);
        step(mk("lu_bubble", 0, 0, 0, 0, 0, 1, 0), 1);
        idle(); dec(7, 1, 2, 1, 8, 1, 0, 32'h0, 32'h22);
        mem_regwren_i = 1; mem_rd_i = 7; mem_data_i = 32'hDEADBEEF;
        step(mk("lu_mem", 1, 1, 32'hDEADBEEF, 1, 32'h22, 1, 0), 0);

        // WB bypass with stale register file, x0 read; this instruction writes x0
        idle(); dec(9, 1, 0, 1, 0, 1, 0, 32'h11, 32'h77); ex_result_i = 32'hEE;
        wb_regwren_i = 1; wb_rd_i = 9; wb_data_i = 32'h55;
        step(mk("wb_x0", 1, 1, 32'h55, 1, 0, 1, 0), 0);
        // x0 writers in EX, MEM and WB are never forwarded
        idle(); dec(0, 1, 0, 1, 12, 1, 0, 32'h31, 32'h32); ex_result_i = 32'hCC;
        mem_regwren_i = 1; mem_rd_i = 0; mem_data_i = 32'hAA;
        wb_regwren_i = 1; wb_rd_i = 0; wb_data_i = 32'hBB;
        step(mk("x0_writers", 1, 1, 0, 1, 0, 1, 0), 0);

        // MEM beats WB on same register; rs1 falls through to register file
        idle(); dec(4, 1, 3, 1, 13, 1, 1, 32'h44, 32'h33); ex_result_i = 32'hCC;
        mem_regwren_i = 1; mem_rd_i = 3; mem_data_i = 32'hA;
        wb_regwren_i = 1; wb_rd_i = 3; wb_data_i = 32'hB;
        step(mk("mem_wb_prio", 1, 1, 32'h44, 1, 32'hA, 1, 0), 0);

        // Flush wins over a live load-use hazard on x13
        idle(); dec(13, 1, 0, 0, 14, 1, 0, 0, 0); flush_i = 1;
        step(mk("flush_lu", 0, 0, 0, 0, 0, 1, 1), 0);

        // EX beats MEM and WB
        idle(); dec(2, 1, 0, 0, 14, 1, 0, 32'h2222, 0);
        step(mk("ex_setup", 1, 1, 32'h2222, 0, 0, 1, 1), 0);
        idle(); dec(14, 1, 14, 1, 15, 1, 0, 1, 2); ex_result_i = 32'h1414;
        mem_regwren_i = 1; mem_rd_i = 14; mem_data_i = 32'hDD;
        wb_regwren_i = 1; wb_rd_i = 14; wb_data_i = 32'hEE;
        step(mk("ex_prio", 1, 1, 32'h1414, 1, 32'h1414, 1, 1), 0);

        // Back-to-back flushes keep EX empty and saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            idle(); dec(1, 1, 2, 1, 3, 1, 0, 5, 6); flush_i = 1;
            step(mk($sformatf("flush%0d", i), 0, 0, 0, 0, 0, 1, (i + 2 > 15) ? 15 : i + 2), 0);
        end

        // Load in EX, dependent decode stalls, then reset arrives mid-stall
        idle(); dec(0, 0, 0, 0, 15, 1, 1, 0, 0);
        step(mk("lw_x15", 1, 0, 0, 0, 0, 1, 15), 0);
        idle(); dec(0, 0, 15, 1, 16, 1, 0, 0, 0);
        #1;
        chk("pre_rst.stall_o", 32'(stall_o), 1);
        #2 rst = 1;
        #1;
        chk("rst_async.valid", 32'(ex_valid_o), 0);
        chk("rst_async.rd_wr_ld", 32'({ex_rd_o, ex_regwren_o, ex_memren_o}), 0);
        chk("rst_async.pc_insn", ex_pc_o | ex_insn_o, 0);
        chk("rst_async.counts", 32'({stall_cnt_o, flush_cnt_o}), 0);
        chk("rst_async.stall_o", 32'(stall_o), 0);
        @(negedge clk);
        rst = 0;
        idle(); dec(0, 0, 15, 1, 16, 1, 0, 0, 32'h5A5A);
        step(mk("post_rst", 1, 0, 0, 1, 32'h5A5A, 0, 0), 0);

        idle();
        @(posedge clk); #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
